// File: rtl/debug_msg_sched.sv
// rtl/debug_msg_sched.sv - round-robin scheduler serialising four debug message slots onto a UART byte stream
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-low reset
//   req[3:0]  per-requester send request
//   msg       four MSG_BYTES-byte slots; slot i at [(i+1)*MSG_BYTES*8-1 : i*MSG_BYTES*8], MSB byte sent first
//   gnt[3:0]  one-hot grant, held from the grant edge through DONE
//   done[3:0] one-cycle pulse on the granted bit at end of transfer
//   busy      high whenever a transfer is in progress
//   tx_data   byte to the UART transmitter
//   tx_valid  tx_data is valid
//   tx_ready  transmitter accepts tx_data this cycle
//
// Configuration macro DBG_SCHED_CRLF_EN:
//   defined   -> every message is followed by 0x0D, 0x0A
//   undefined -> no terminator; SEND exits straight to DONE
module debug_msg_sched #(
    parameter int MSG_BYTES = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [3:0]               req,
    input  logic [4*MSG_BYTES*8-1:0] msg,
    output logic [3:0]               gnt,
    output logic [3:0]               done,
    output logic                     busy,
    output logic [7:0]               tx_data,
    output logic                     tx_valid,
    input  logic                     tx_ready
);

    localparam int NREQ   = 4;
    localparam int SLOT_W = MSG_BYTES * 8;
    localparam int IDX_W  = (MSG_BYTES > 1) ? $clog2(MSG_BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MSG_BYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
`ifdef DBG_SCHED_CRLF_EN
        S_CR,
        S_LF,
`endif
        S_DONE
    } state_t;

    // Where SEND goes once the message is exhausted.
`ifdef DBG_SCHED_CRLF_EN
    localparam state_t S_TERM = S_CR;
`else
    localparam state_t S_TERM = S_DONE;
`endif

    state_t              state_q, state_d;
    logic [SLOT_W-1:0]   buf_q, buf_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [1:0]          gidx_q, gidx_d;
    logic [1:0]          last_q, last_d;

    logic [1:0]          pick;
    logic                pick_vld;
    logic [SLOT_W-1:0]   slot_sel;
    logic [SLOT_W-1:0]   buf_shift;
    logic [7:0]          cur_byte;
    logic [3:0]          gnt_oh;

    // Round-robin pick: scan from last+4 (lowest priority) down to last+1 so the
    // requester nearest after the last grant overwrites the others.
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        for (int k = NREQ; k >= 1; k--) begin
            if (req[last_q + 2'(k)]) begin
                pick     = last_q + 2'(k);
                pick_vld = 1'b1;
            end
        end
    end

    always_comb begin
        slot_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick == 2'(i)) begin
                slot_sel = msg[i*SLOT_W +: SLOT_W];
            end
        end
    end

    // Byte 0 is the slot MSB, so shifting left by 8*index brings the current byte to the top.
    assign buf_shift = buf_q << {idx_q, 3'b000};
    assign cur_byte  = buf_shift[SLOT_W-1 -: 8];

    assign gnt_oh = 4'b0001 << gidx_q;
    assign busy   = (state_q != S_IDLE);
    assign gnt    = busy ? gnt_oh : 4'b0000;

    always_comb begin
        state_d  = state_q;
        buf_d    = buf_q;
        idx_d    = idx_q;
        gidx_d   = gidx_q;
        last_d   = last_q;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        done     = 4'b0000;
        case (state_q)
            S_IDLE: begin
                if (pick_vld) begin
                    state_d = S_SEND;
                    buf_d   = slot_sel;
                    idx_d   = '0;
                    gidx_d  = pick;
                end
            end
            S_SEND: begin
                tx_data = cur_byte;
                if (cur_byte == 8'h00) begin
                    // A zero byte ends the message and is never offered to the transmitter.
                    state_d = S_TERM;
                end else begin
                    tx_valid = 1'b1;
                    if (tx_ready) begin
                        if (idx_q == LAST_IDX) begin
                            state_d = S_TERM;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end
                end
            end
`ifdef DBG_SCHED_CRLF_EN
            S_CR: begin
                tx_data  = 8'h0D;
                tx_valid = 1'b1;
                if (tx_ready) begin
                    state_d = S_LF;
                end
            end
            S_LF: begin
                tx_data  = 8'h0A;
                tx_valid = 1'b1;
                if (tx_ready) begin
                    state_d = S_DONE;
                end
            end
`endif
            S_DONE: begin
                done    = gnt_oh;
                last_d  = gidx_q;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Pointer resets to 3 so requester 0 is first in line after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            buf_q   <= '0;
            idx_q   <= '0;
            gidx_q  <= '0;
            last_q  <= 2'd3;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            idx_q   <= idx_d;
            gidx_q  <= gidx_d;
            last_q  <= last_d;
        end
    end

endmodule

// File: tb/tb_debug_msg_sched.sv
// tb/tb_debug_msg_sched.sv - self-checking bench for debug_msg_sched
module tb_debug_msg_sched;

    localparam int MB = 16;
    localparam int SW = MB * 8;
`ifdef DBG_SCHED_CRLF_EN
    localparam bit CRLF = 1'b1;
`else
    localparam bit CRLF = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [3:0]      req = 4'b0000;
    logic [4*SW-1:0] msg = '0;
    logic [3:0]      gnt;
    logic [3:0]      done;
    logic            busy;
    logic [7:0]      tx_data;
    logic            tx_valid;
    logic            tx_ready = 1'b0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    debug_msg_sched #(.MSG_BYTES(MB)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .msg      (msg),
        .gnt      (gnt),
        .done     (done),
        .busy     (busy),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready)
    );

    logic [7:0] sb [4][MB];
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    logic [3:0] got_gnt;
    int grant_cyc, done_cyc, done_cnt, stab_err, gnt_err;
    int model_ptr;

    typedef struct {
        logic [3:0] req;
        int         len;
        logic [7:0] base;
        int         mode;
        int         exp_g;
    } vec_t;

    vec_t vt[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic apply_msg();
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < MB; j++)
                msg[i*SW + (MB-1-j)*8 +: 8] = sb[i][j];
    endtask

    task automatic fill_filler();
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < MB; j++)
                sb[i][j] = 8'hA0 + 8'(i);
    endtask

    task automatic fill_slot(input int s, input int len, input logic [7:0] base);
        for (int j = 0; j < MB; j++)
            sb[s][j] = (j < len) ? base + 8'(j) : 8'h00;
    endtask

    // Reference: bytes up to the first zero or the slot end, then the terminator.
    task automatic build_exp(input int g);
        exp_q.delete();
        for (int j = 0; j < MB; j++) begin
            if (sb[g][j] == 8'h00) break;
            exp_q.push_back(sb[g][j]);
        end
        if (CRLF) begin
            exp_q.push_back(8'h0D);
            exp_q.push_back(8'h0A);
        end
    endtask

    function automatic int rr_pick(input int ptr, input logic [3:0] r);
        for (int k = 1; k <= 4; k++)
            if (r[(ptr + k) % 4]) return (ptr + k) % 4;
        return -1;
    endfunction

    function automatic int exp_done_cyc(input int len);
        return 1 + len + ((len < MB) ? 1 : 0) + (CRLF ? 2 : 0);
    endfunction

    task automatic cmp_bytes(input string name);
        int diff;
        checks++;
        diff = -1;
        if (got_q.size() != exp_q.size()) diff = 0;
        else
            for (int i = 0; i < exp_q.size(); i++)
                if (got_q[i] !== exp_q[i] && diff < 0) diff = i;
        if (diff >= 0) begin
            errors++;
            $display("FAIL %s: got %0d bytes expected %0d bytes (first diff at %0d)",
                     name, got_q.size(), exp_q.size(), diff);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
    // mode: 0 ready always, 1 ready pattern 0,0,1, 2 random ready.
    task automatic do_transfer(input logic [3:0] r, input int mode, input bit scramble);
        logic [7:0] pd;
        logic       pv, pr;
        got_q.delete();
        got_gnt = 4'b0000; grant_cyc = -1; done_cyc = -1;
        done_cnt = 0; stab_err = 0; gnt_err = 0;
        pv = 1'b0; pr = 1'b1; pd = 8'h00;
        req = r;
        for (int cyc = 1; cyc <= 400; cyc++) begin
            @(negedge clk);
            if (gnt != 4'b0000 && grant_cyc < 0) begin
                grant_cyc = cyc;
                got_gnt   = gnt;
            end
            if (grant_cyc >= 0 && gnt !== got_gnt) gnt_err++;
            if (pv && !pr && (tx_valid !== pv || tx_data !== pd)) stab_err++;
            if (done != 4'b0000) begin
                done_cnt++;
                done_cyc = cyc;
                if (done !== got_gnt) gnt_err++;
            end
            case (mode)
                0:       tx_ready = 1'b1;
                1:       tx_ready = (cyc % 3 == 0);
                default: tx_ready = 1'($urandom_range(0, 1));
            endcase
            if (tx_valid && tx_ready) got_q.push_back(tx_data);
            pv = tx_valid; pd = tx_data; pr = tx_ready;
            if (scramble && grant_cyc >= 0) begin
                req = 4'($urandom);
                for (int i = 0; i < 4; i++)
                    for (int j = 0; j < MB; j++)
                        sb[i][j] = 8'($urandom);
                apply_msg();
            end
            if (done != 4'b0000) begin
                req = 4'b0000;
                break;
            end
        end
        req = 4'b0000;
        @(negedge clk);
        check("idle_outputs", {14'd0, busy, gnt, done, tx_valid, tx_data}, 32'd0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        model_ptr = 3;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int g, ng, prev_cyc, acc_cnt, rst_done;
        logic [3:0] prev_gnt;
        int order[5];
        int onset[5];

        // Reset state, with requests pending to show they are ignored.
        req = 4'b1111;
        fill_filler();
        apply_msg();
        #12;
        check("reset_outputs", {14'd0, busy, gnt, done, tx_valid, tx_data}, 32'd0);
        repeat (3) @(negedge clk);
        check("reset_held_outputs", {14'd0, busy, gnt, done, tx_valid, tx_data}, 32'd0);
        req = 4'b0000;
        rst = 1'b1;
        model_ptr = 3;
        @(negedge clk);
        check("post_reset_idle", {14'd0, busy, gnt, done, tx_valid, tx_data}, 32'd0);

        // V2: all requesting continuously, 1-byte messages.
        for (int i = 0; i < 4; i++) fill_slot(i, 1, 8'h61 + 8'(i));
        apply_msg();
        tx_ready = 1'b1;
        req = 4'b1111;
        ng = 0;
        prev_gnt = 4'b0000;
        for (int cyc = 1; cyc <= 60 && ng < 5; cyc++) begin
            @(negedge clk);
            if (gnt != 4'b0000 && prev_gnt == 4'b0000) begin
                order[ng] = (gnt == 4'b0001) ? 0 : (gnt == 4'b0010) ? 1 :
                            (gnt == 4'b0100) ? 2 : (gnt == 4'b1000) ? 3 : 9;
                onset[ng] = cyc;
                ng++;
            end
            prev_gnt = gnt;
        end
        req = 4'b0000;
        check("v2_grant_count", ng, 5);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("v2_order%0d", i), (i < ng) ? order[i] : -1, i % 4);
            if (i > 0)
                check($sformatf("v2_spacing%0d", i), (i < ng) ? onset[i] - onset[i-1] : -1,
                      CRLF ? 6 : 4);
        end
        for (int cyc = 0; cyc < 40 && busy; cyc++) @(negedge clk);
        check("v2_back_idle", busy, 1'b0);
        model_ptr = 0;

        // Table-driven transfers: V1, V3, V4, round-robin rotations, MSG_BYTES-1, V6.
        vt[0] = '{4'b0001,  2, 8'h68, 0, 0};
        vt[1] = '{4'b0100, 16, 8'h41, 0, 2};
        vt[2] = '{4'b1000,  4, 8'h21, 1, 3};
        vt[3] = '{4'b1010,  3, 8'h70, 0, 1};
        vt[4] = '{4'b1011,  1, 8'h7A, 0, 3};
        vt[5] = '{4'b1001, 15, 8'h30, 2, 0};
        vt[6] = '{4'b0010,  0, 8'h00, 0, 1};
        vt[7] = '{4'b0011,  5, 8'h50, 0, 0};
        for (int i = 0; i < 8; i++) begin
            fill_filler();
            fill_slot(vt[i].exp_g, vt[i].len, vt[i].base);
            apply_msg();
            build_exp(vt[i].exp_g);
            do_transfer(vt[i].req, vt[i].mode, 1'b0);
            check($sformatf("row%0d_gnt", i), got_gnt, 4'b0001 << vt[i].exp_g);
            check($sformatf("row%0d_grant_lat", i), grant_cyc, 1);
            cmp_bytes($sformatf("row%0d_bytes", i));
            check($sformatf("row%0d_done_cnt", i), done_cnt, 1);
            check($sformatf("row%0d_stable", i), stab_err, 0);
            check($sformatf("row%0d_gnt_hold", i), gnt_err, 0);
            if (vt[i].mode == 0)
                check($sformatf("row%0d_done_cyc", i), done_cyc, exp_done_cyc(vt[i].len));
            model_ptr = vt[i].exp_g;
        end

        // V5: reset after the second byte of a 5-byte message.
        fill_filler();
        fill_slot(1, 5, 8'h31);
        apply_msg();
        tx_ready = 1'b1;
        req = 4'b0010;
        acc_cnt = 0;
        for (int cyc = 1; cyc <= 2; cyc++) begin
            @(negedge clk);
            if (tx_valid && tx_ready) acc_cnt++;
        end
        @(negedge clk);
        check("v5_third_byte", tx_data, 8'h33);
        check("v5_accepted", acc_cnt, 2);
        #2 rst = 1'b0;
        #1;
        check("v5_async_clear", {14'd0, busy, gnt, done, tx_valid, tx_data}, 32'd0);
        rst_done = 0;
        repeat (3) begin
            @(negedge clk);
            if (done != 4'b0000) rst_done++;
        end
        check("v5_no_done", rst_done, 0);
        rst = 1'b1;
        model_ptr = 3;
        build_exp(1);
        do_transfer(4'b0010, 0, 1'b0);
        check("v5_regrant", got_gnt, 4'b0010);
        check("v5_grant_lat", grant_cyc, 1);
        cmp_bytes("v5_bytes");
        model_ptr = 1;

        // Reset returns priority to requester 0.
        pulse_reset();
        fill_filler();
        fill_slot(0, 2, 8'h11);
        apply_msg();
        build_exp(0);
        do_transfer(4'b1111, 0, 1'b0);
        check("ptr_reset_gnt", got_gnt, 4'b0001);
        cmp_bytes("ptr_reset_bytes");
        model_ptr = 0;

        // Randomised transfers with inputs scrambled after each grant.
        for (int t = 0; t < 40; t++) begin
            logic [3:0] r;
            r = 4'($urandom_range(1, 15));
            for (int i = 0; i < 4; i++) begin
                int len;
                len = $urandom_range(0, MB);
                for (int j = 0; j < MB; j++)
                    sb[i][j] = (j < len) ? 8'($urandom_range(1, 255)) : 8'h00;
            end
            apply_msg();
            g = rr_pick(model_ptr, r);
            build_exp(g);
            do_transfer(r, 2, 1'b1);
            check($sformatf("rnd%0d_gnt", t), got_gnt, 4'b0001 << g);
            cmp_bytes($sformatf("rnd%0d_bytes", t));
            check($sformatf("rnd%0d_done_cnt", t), done_cnt, 1);
            check($sformatf("rnd%0d_stable", t), stab_err, 0);
            check($sformatf("rnd%0d_gnt_hold", t), gnt_err, 0);
            model_ptr = g;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
